id_register_file_sb: RTL and testbench

//  Parametrised ID-stage register file for the MIPS32 pipeline: NUM_READ combinational read ports and one WB write port.

---
 rtl/id_register_file_sb_pkg.sv | 17 +
 rtl/id_register_file_sb_if.sv | 30 +++
 rtl/id_reg_scoreboard.sv | 51 +++++
 rtl/id_register_file_sb.sv | 67 ++++++
 tb/tb_id_register_file_sb.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/id_register_file_sb_pkg.sv
// Shared defaults and constants for the ID-stage register file with pending-write scoreboard.
package id_register_file_sb_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_READ = 2;
  localparam int DEF_CNT_W    = 2;
  localparam int DEF_BYPASS   = 1;

  // Hard-wired zero register: never written, never reserved, always reads 0.
  localparam int REG_ZERO = 0;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/id_register_file_sb_if.sv
// Decode/writeback side bundle of the register file: read ports, reserve strobe, WB write and status.
// Reserve_ID and RegWrite_WB are single-cycle strobes with no back-pressure: each cycle they are high is one event.
interface id_register_file_sb_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
);
  logic [NUM_READ*ADDR_W-1:0] Read_Address_ID;
  logic [NUM_READ*DATA_W-1:0] Read_Data_ID;
  logic [NUM_READ-1:0]        Busy_ID;
  logic                       Reserve_ID;
  logic [ADDR_W-1:0]          Reserve_Register_ID;
  logic                       RegWrite_WB;
  logic [ADDR_W-1:0]          Write_Register_WB;
  logic [DATA_W-1:0]          Write_Data_WB;
  logic                       Sb_Overflow;
  logic                       Sb_Underflow;

  modport master (
    output Read_Address_ID, Reserve_ID, Reserve_Register_ID,
    output RegWrite_WB, Write_Register_WB, Write_Data_WB,
    input  Read_Data_ID, Busy_ID, Sb_Overflow, Sb_Underflow
  );

  modport slave (
    input  Read_Address_ID, Reserve_ID, Reserve_Register_ID,
    input  RegWrite_WB, Write_Register_WB, Write_Data_WB,
    output Read_Data_ID, Busy_ID, Sb_Overflow, Sb_Underflow
  );
endinterface

// File: rtl/id_reg_scoreboard.sv
// Per-register pending-write counters: issue reserves, WB releases, sticky overflow/underflow flags.
module id_reg_scoreboard
  import id_register_file_sb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int NUM_READ = DEF_NUM_READ
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_reg,
  input  logic                       rel_en,
  input  logic [ADDR_W-1:0]          rel_reg,
  input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
  output logic [NUM_READ-1:0]        busy,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int              DEPTH   = depth_of(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [DEPTH];
  logic rsv_live, rel_live, same_reg, ovf_evt, unf_evt;

  assign rsv_live = rsv_en && (rsv_reg != ADDR_W'(REG_ZERO));
  assign rel_live = rel_en && (rel_reg != ADDR_W'(REG_ZERO));
  // Reserve and release of the same register cancel out, even at the count limits.
  assign same_reg = rsv_live && rel_live && (rsv_reg == rel_reg);
  assign ovf_evt  = rsv_live && !same_reg && (cnt[rsv_reg] == CNT_MAX);
  assign unf_evt  = rel_live && !same_reg && (cnt[rel_reg] == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) cnt[r] <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (rsv_live && !same_reg && !ovf_evt) cnt[rsv_reg] <= cnt[rsv_reg] + CNT_W'(1);
      if (rel_live && !same_reg && !unf_evt) cnt[rel_reg] <= cnt[rel_reg] - CNT_W'(1);
      if (ovf_evt) overflow  <= 1'b1;
      if (unf_evt) underflow <= 1'b1;
    end
  end

  // Busy reflects registered counts, so it rises the cycle after a reserve.
  for (genvar k = 0; k < NUM_READ; k++) begin : g_busy
    assign busy[k] = (cnt[rd_addr[k*ADDR_W +: ADDR_W]] != '0);
  end

endmodule

// File: rtl/id_register_file_sb.sv
// MIPS32 ID-stage register file: NUM_READ combinational reads, one WB write with optional write-through, plus scoreboard.
module id_register_file_sb
  import id_register_file_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_READ = DEF_NUM_READ,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int BYPASS   = DEF_BYPASS
) (
  input logic                   Clk,
  input logic                   Reset_n,
  id_register_file_sb_if.slave  rf
);
  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0]   register_file [DEPTH];
  logic                wr_live;
  logic [NUM_READ-1:0] busy_raw;

  assign wr_live = rf.RegWrite_WB && (rf.Write_Register_WB != ADDR_W'(REG_ZERO));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int r = 0; r < DEPTH; r++) register_file[r] <= '0;
    end else if (wr_live) begin
      register_file[rf.Write_Register_WB] <= rf.Write_Data_WB;
    end
  end

  id_reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W),
    .NUM_READ (NUM_READ)
  ) u_scoreboard (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .rsv_en    (rf.Reserve_ID),
    .rsv_reg   (rf.Reserve_Register_ID),
    .rel_en    (rf.RegWrite_WB),
    .rel_reg   (rf.Write_Register_WB),
    .rd_addr   (rf.Read_Address_ID),
    .busy      (busy_raw),
    .overflow  (rf.Sb_Overflow),
    .underflow (rf.Sb_Underflow)
  );

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rf.Read_Address_ID[k*ADDR_W +: ADDR_W];

    // Outputs are held at zero while reset is asserted, independent of stored state.
    always_comb begin
      data = '0;
      if (Reset_n && (addr != ADDR_W'(REG_ZERO))) begin
        if ((BYPASS != 0) && wr_live && (rf.Write_Register_WB == addr)) data = rf.Write_Data_WB;
        else                                                            data = register_file[addr];
      end
    end

    assign rf.Read_Data_ID[k*DATA_W +: DATA_W] = data;
    assign rf.Busy_ID[k]                       = busy_raw[k] & Reset_n;
  end

endmodule

// File: tb/tb_id_register_file_sb.sv
// Bench for id_register_file_sb: BYPASS=1 and BYPASS=0 instances driven in lockstep, checked against an array model.
module tb_id_register_file_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int CW = 2;
  localparam int CMAX = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus variables ----------------
  logic [AW-1:0] ra [NR];
  logic          rsv = 1'b0;
  logic [AW-1:0] rsv_reg = '0;
  logic          we = 1'b0;
  logic [AW-1:0] wr_reg = '0;
  logic [DW-1:0] wr_data = '0;
  bit            check_en = 1'b0;

  int checks = 0;
  int errors = 0;

  id_register_file_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR)) rf1 ();
  id_register_file_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR)) rf0 ();

  assign rf1.Read_Address_ID     = {ra[2], ra[1], ra[0]};
  assign rf1.Reserve_ID          = rsv;
  assign rf1.Reserve_Register_ID = rsv_reg;
  assign rf1.RegWrite_WB         = we;
  assign rf1.Write_Register_WB   = wr_reg;
  assign rf1.Write_Data_WB       = wr_data;
  assign rf0.Read_Address_ID     = {ra[2], ra[1], ra[0]};
  assign rf0.Reserve_ID          = rsv;
  assign rf0.Reserve_Register_ID = rsv_reg;
  assign rf0.RegWrite_WB         = we;
  assign rf0.Write_Register_WB   = wr_reg;
  assign rf0.Write_Data_WB       = wr_data;

  id_register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .CNT_W(CW), .BYPASS(1)) dut_byp (
    .Clk(clk), .Reset_n(rst_n), .rf(rf1)
  );
  id_register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .CNT_W(CW), .BYPASS(0)) dut_nobyp (
    .Clk(clk), .Reset_n(rst_n), .rf(rf0)
  );

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [32];
  int            m_cnt [32];
  bit            m_ovf, m_unf;

  initial begin
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_cnt[i] = 0; end
    m_ovf = 0; m_unf = 0;
    for (int i = 0; i < NR; i++) ra[i] = '0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_cnt[i] = 0; end
      m_ovf = 0; m_unf = 0;
    end else begin
      bit r_ok, w_ok;
      r_ok = rsv && (rsv_reg != 0);
      w_ok = we && (wr_reg != 0);
      if (w_ok) m_mem[wr_reg] = wr_data;
      if (!(r_ok && w_ok && rsv_reg == wr_reg)) begin
        if (r_ok) begin
          if (m_cnt[rsv_reg] == CMAX) m_ovf = 1; else m_cnt[rsv_reg] = m_cnt[rsv_reg] + 1;
        end
        if (w_ok) begin
          if (m_cnt[wr_reg] == 0) m_unf = 1; else m_cnt[wr_reg] = m_cnt[wr_reg] - 1;
        end
      end
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (!rst_n || a == 0) return '0;
    if (byp && we && wr_reg == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic [DW-1:0] exp_busy(input logic [AW-1:0] a);
    return (rst_n && a != 0 && m_cnt[a] > 0) ? 32'd1 : 32'd0;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("byp rd%0d", k),   rf1.Read_Data_ID[k*DW +: DW], exp_rd(ra[k], 1'b1));
        chk($sformatf("nobyp rd%0d", k), rf0.Read_Data_ID[k*DW +: DW], exp_rd(ra[k], 1'b0));
        chk($sformatf("byp busy%0d", k),   {31'd0, rf1.Busy_ID[k]}, exp_busy(ra[k]));
        chk($sformatf("nobyp busy%0d", k), {31'd0, rf0.Busy_ID[k]}, exp_busy(ra[k]));
      end
      chk("byp ovf",   {31'd0, rf1.Sb_Overflow},  {31'd0, m_ovf});
      chk("byp unf",   {31'd0, rf1.Sb_Underflow}, {31'd0, m_unf});
      chk("nobyp ovf", {31'd0, rf0.Sb_Overflow},  {31'd0, m_ovf});
      chk("nobyp unf", {31'd0, rf0.Sb_Underflow}, {31'd0, m_unf});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit rn, input bit r, input int rr, input bit w, input int wr,
                      input logic [DW-1:0] wd, input int a0, input int a1, input int a2);
    @(posedge clk);
    #1;
    rst_n   = rn;
    rsv     = r;
    rsv_reg = AW'(rr);
    we      = w;
    wr_reg  = AW'(wr);
    wr_data = wd;
    ra[0]   = AW'(a0);
    ra[1]   = AW'(a1);
    ra[2]   = AW'(a2);
    @(negedge clk);
  endtask

  task automatic idle(input int a0, input int a1, input int a2);
    step(1, 0, 0, 0, 0, '0, a0, a1, a2);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, '0, 0, 0, 0);
    idle(0, 0, 0);
  endtask

  function automatic logic [DW-1:0] port(input bit byp, input int k);
    return byp ? rf1.Read_Data_ID[k*DW +: DW] : rf0.Read_Data_ID[k*DW +: DW];
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    // Reset and sweep r1..r31
    step(0, 0, 0, 0, 0, '0, 0, 0, 0);
    check_en = 1'b1;
    for (int a = 1; a < 32; a += 3) begin
      idle(a, (a + 1) % 32, (a + 2) % 32);
      for (int k = 0; k < NR; k++) chk("reset read zero", port(1, k), 32'h0);
      chk("reset busy zero", {29'd0, rf1.Busy_ID}, 32'h0);
    end
    chk("reset ovf", {31'd0, rf1.Sb_Overflow}, 32'h0);
    chk("reset unf", {31'd0, rf1.Sb_Underflow}, 32'h0);

    // Write with same-cycle read
    step(1, 0, 0, 1, 5, 32'hDEADBEEF, 5, 5, 0);
    chk("bypass same cycle", port(1, 0), 32'hDEADBEEF);
    chk("no-bypass same cycle old", port(0, 0), 32'h0);
    idle(5, 5, 0);
    chk("bypass next cycle", port(1, 0), 32'hDEADBEEF);
    chk("no-bypass next cycle", port(0, 0), 32'hDEADBEEF);
    do_reset();

    // Register zero
    step(1, 1, 0, 1, 0, 32'h12345678, 0, 0, 0);
    chk("r0 read", port(1, 0), 32'h0);
    idle(0, 0, 0);
    chk("r0 busy", {31'd0, rf1.Busy_ID[0]}, 32'h0);
    chk("r0 ovf", {31'd0, rf1.Sb_Overflow}, 32'h0);
    chk("r0 unf", {31'd0, rf1.Sb_Underflow}, 32'h0);

    // Scoreboard fill to max, overflow, drain
    step(1, 1, 7, 0, 0, '0, 7, 7, 7);
    chk("r7 busy before first reserve lands", {31'd0, rf1.Busy_ID[0]}, 32'h0);
    step(1, 1, 7, 0, 0, '0, 7, 7, 7);
    chk("r7 busy after first reserve", {31'd0, rf1.Busy_ID[0]}, 32'h1);
    step(1, 1, 7, 0, 0, '0, 7, 7, 7);
    step(1, 1, 7, 0, 0, '0, 7, 7, 7);
    chk("ovf not yet", {31'd0, rf1.Sb_Overflow}, 32'h0);
    step(1, 0, 0, 1, 7, 32'h70, 7, 7, 7);
    chk("ovf set", {31'd0, rf1.Sb_Overflow}, 32'h1);
    chk("model cnt r7 at max", 32'(m_cnt[7]), 32'd3);
    step(1, 0, 0, 1, 7, 32'h71, 7, 7, 7);
    step(1, 0, 0, 1, 7, 32'h72, 7, 7, 7);
    chk("r7 busy during last release", {31'd0, rf1.Busy_ID[0]}, 32'h1);
    idle(7, 7, 7);
    chk("r7 busy cleared", {31'd0, rf1.Busy_ID[0]}, 32'h0);
    chk("r7 data", port(1, 0), 32'h72);
    do_reset();

    // Simultaneous reserve/release at zero, then lone release at zero
    step(1, 1, 9, 1, 9, 32'h99, 9, 9, 9);
    chk("r9 bypass", port(1, 0), 32'h99);
    idle(9, 9, 9);
    chk("r9 busy", {31'd0, rf1.Busy_ID[0]}, 32'h0);
    chk("r9 no unf", {31'd0, rf1.Sb_Underflow}, 32'h0);
    chk("r9 written", port(0, 0), 32'h99);
    step(1, 0, 0, 1, 10, 32'h10, 10, 0, 0);
    idle(10, 0, 0);
    chk("r10 unf", {31'd0, rf1.Sb_Underflow}, 32'h1);

    // Multi-port, then reset with pending count
    step(1, 0, 0, 1, 4, 32'hA5A5A5A5, 4, 4, 0);
    chk("mp port0", port(1, 0), 32'hA5A5A5A5);
    chk("mp port1", port(1, 1), 32'hA5A5A5A5);
    chk("mp port2", port(1, 2), 32'h0);
    step(1, 1, 4, 0, 0, '0, 4, 4, 0);
    step(1, 1, 4, 0, 0, '0, 4, 4, 0);
    idle(4, 4, 0);
    chk("r4 busy pending", {31'd0, rf1.Busy_ID[0]}, 32'h1);
    step(0, 0, 0, 0, 0, '0, 4, 4, 0);
    chk("r4 forced during reset", port(1, 0), 32'h0);
    idle(4, 4, 0);
    chk("r4 busy after reset", {31'd0, rf1.Busy_ID[0]}, 32'h0);
    chk("r4 data after reset", port(1, 0), 32'h0);

    // Randomized traffic on a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      bit rn, r, w;
      int rr, wr;
      rn = ($urandom_range(0, 199) != 0);
      r  = ($urandom_range(0, 1) == 1);
      w  = ($urandom_range(0, 1) == 1);
      rr = $urandom_range(0, 7);
      wr = $urandom_range(0, 7);
      step(rn, r, rr, w, wr, $urandom, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 31));
    end

    check_en = 1'b0;
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
